vchanel_demux: RTL and testbench
================================

Name: vchanel_demux

Overview:
- Ingress side of the virtual-channel path: takes one 4-bit data stream tagged with a destination channel and steers each beat into one of four virtual-channel FIFOs (vchanel0..3).
- The weighted round-robin drains those FIFOs on the egress side.
- Tracks free space in each FIFO with a per-channel credit counter. Credits are returned by the FIFO's reader pops.
- Back-pressures the source through a valid/ready handshake, so no FIFO can ever overflow.

Parameters:
- DATA_W, 4: payload width.
- FIFO_DEPTH, 4: entries per virtual-channel FIFO; also the initial credit count.
- CNT_W, 3: credit counter width; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- enb  in  1  block enable; when low, no new beats are accepted.
- in_valid  in  1  source has a beat.
- in_dest  in  2  destination channel of the beat (0..3).
- in_data  in  DATA_W  beat payload.
- in_ready  out  1  block accepts the beat this cycle.
- pop_vchanel  in  4  bit i = FIFO i was read this cycle (credit return).
- push_vchanel0..3  out  1 each  write strobe into FIFO i.
- data_demux  out  DATA_W  write data, shared by all four FIFOs.
- full_vchanel  out  4  bit i = channel i has zero credits.
- overflow_err  out  1  sticky: a pop arrived while the channel already held FIFO_DEPTH credits.

Behaviour:
- Reset (rst=0, asynchronous, any time):
  - push_vchanel0..3 = 0, data_demux = 0, overflow_err = 0.
  - All credits = FIFO_DEPTH, so full_vchanel = 4'b0000.
  - in_ready = 0 while rst=0.
  - Reset mid-transfer drops any registered beat; no push is issued for it.
- in_ready (combinational) = enb & rst & (credit[in_dest] != 0).
  - It depends on in_dest; the source must hold in_dest stable while in_valid=1.
- Accept: occurs at a posedge when in_valid & in_ready.
- Latency: a beat accepted at edge N produces, during cycle N+1:
  - push_vchanel[in_dest] = 1 for exactly one cycle;
  - data_demux = in_data.
- Throughput: one beat per cycle. At most one push strobe is high in any cycle. data_demux holds its last value when no push is active.
- Credit update per channel i, every edge:
  - credit_next = credit - acc_i + pop_i, where acc_i = accept with in_dest == i.
  - acc_i and pop_i in the same cycle leave the credit unchanged; this is legal even when credit = 1.
  - The credit is decremented at accept, not at push, so the one-cycle pipeline cannot oversubscribe the FIFO.
- full_vchanel[i] = (credit[i] == 0), registered-state based, with no extra latency.
- Pop at credit == FIFO_DEPTH without a simultaneous accept on that channel:
  - the pop is ignored and the credit saturates at FIFO_DEPTH;
  - overflow_err is set and held until reset.
- Pops on several channels in the same cycle are all honoured.
- enb = 0:
  - in_ready = 0;
  - a beat already registered still issues its push in the next cycle;
  - credit returns continue.
- in_valid=1 with credit[in_dest] = 0: the beat is stalled and the source holds it. There is no head-of-line bypass to other channels.
- State machine per channel, derived from the credit count (no separate encoding):
  - FREE: credit = FIFO_DEPTH.
  - PARTIAL: 0 < credit < FIFO_DEPTH.
  - FULL: credit = 0.
  - Transitions occur only through accept and pop as defined above.

Decomposition:
- Shared package/header vchanel_defs:
  - VCHANEL0..3 = 2'b00..2'b11 (same encoding as the round-robin arbiter select);
  - NUM_VCHANEL = 4;
  - default DATA_W and FIFO_DEPTH.
- One sub-module, vchanel_credit_cnt:
  - inputs: clk, rst, acc, pop;
  - outputs: credit, full, ovf;
  - instantiated four times.
- The top level holds the accept logic, the output register and the sticky error OR.

Test Plan (FIFO_DEPTH=4):
1. Reset release, then in_valid=1 with in_dest=2, in_data=4'hC for one cycle -> one cycle later push_vchanel2=1 and data_demux=4'hC; all other pushes stay 0.
2. Five consecutive beats to channel 0 (4'h1..4'h5) with no pops -> four pushes (4'h1..4'h4); full_vchanel=4'b0001 after the 4th accept; in_ready=0 with the 5th beat held. Then pop_vchanel[0]=1 for one cycle -> beat 4'h5 is accepted next edge and pushed one cycle later.
3. Channel 3 at credit 1; accept to ch3 and pop_vchanel[3] in the same cycle -> credit stays 1, full_vchanel[3]=0, in_ready remains 1.
4. Back-to-back beats to dest 1,3,0,2 with data 4'hB,4'hD,4'hA,4'h9 -> pushes on 1,3,0,2 in consecutive cycles with matching data_demux, exactly one strobe per cycle.
5. pop_vchanel=4'b0010 while ch1 is at full credit -> overflow_err=1 and held; ch1 credit stays 4.
6. Drop enb to 0 in the cycle of an accept -> the registered push still occurs, in_ready=0 afterwards. Assert rst=0 asynchronously mid-stream -> push_vchanel0..3=0 immediately, credits back to 4, overflow_err=0.

Source files
------------

// File: rtl/vchanel_defs_pkg.sv
// Shared definitions for the virtual-channel ingress path: channel encoding
// (same as the round-robin arbiter select) and default sizing.
package vchanel_defs_pkg;

  localparam int NUM_VCHANEL    = 4;
  localparam int DEF_DATA_W     = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_W      = 3;

  typedef enum logic [1:0] {
    VCHANEL0 = 2'b00,
    VCHANEL1 = 2'b01,
    VCHANEL2 = 2'b10,
    VCHANEL3 = 2'b11
  } vchanel_e;

endpackage

// File: rtl/vchanel_credit_cnt.sv
// Per-channel credit counter: one credit per free FIFO entry, taken at accept
// and returned by the FIFO reader's pop; flags a pop that would exceed the depth.
module vchanel_credit_cnt
  import vchanel_defs_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic             pop,
  output logic [CNT_W-1:0] credit,
  output logic             full,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  // Accept and pop together cancel out; a lone pop at full credit is an error
  // and saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= DEPTH;
      ovf    <= 1'b0;
    end else if (acc && !pop) begin
      credit <= credit - CNT_W'(1);
    end else if (pop && !acc) begin
      if (credit == DEPTH) begin
        ovf <= 1'b1;
      end else begin
        credit <= credit + CNT_W'(1);
      end
    end
  end

  assign full = (credit == '0);

endmodule

// File: rtl/vchanel_demux.sv
// Steers a tagged beat stream into four virtual-channel FIFOs, back-pressuring
// the source from per-channel credits so no FIFO can overflow.
module vchanel_demux
  import vchanel_defs_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   in_valid,
  input  logic [1:0]             in_dest,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic [NUM_VCHANEL-1:0] pop_vchanel,
  output logic                   push_vchanel0,
  output logic                   push_vchanel1,
  output logic                   push_vchanel2,
  output logic                   push_vchanel3,
  output logic [DATA_W-1:0]      data_demux,
  output logic [NUM_VCHANEL-1:0] full_vchanel,
  output logic                   overflow_err
);

  logic [CNT_W-1:0]       credit [NUM_VCHANEL];
  logic [NUM_VCHANEL-1:0] acc;
  logic [NUM_VCHANEL-1:0] ovf;
  logic [NUM_VCHANEL-1:0] push_q;
  logic                   accept;

  // No head-of-line bypass: readiness looks only at the addressed channel.
  assign in_ready = enb & rst & (credit[in_dest] != '0);
  assign accept   = in_valid & in_ready;

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_VCHANEL; i++) begin
      acc[i] = accept && (in_dest == 2'(i));
    end
  end

  for (genvar g = 0; g < NUM_VCHANEL; g++) begin : g_credit
    vchanel_credit_cnt #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
    ) u_credit (
      .clk    (clk),
      .rst    (rst),
      .acc    (acc[g]),
      .pop    (pop_vchanel[g]),
      .credit (credit[g]),
      .full   (full_vchanel[g]),
      .ovf    (ovf[g])
    );
  end

  // One-cycle output stage; data holds between pushes so FIFOs see stable data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_q     <= '0;
      data_demux <= '0;
    end else begin
      push_q <= acc;
      if (accept) begin
        data_demux <= in_data;
      end
    end
  end

  assign push_vchanel0 = push_q[VCHANEL0];
  assign push_vchanel1 = push_q[VCHANEL1];
  assign push_vchanel2 = push_q[VCHANEL2];
  assign push_vchanel3 = push_q[VCHANEL3];
  assign overflow_err  = |ovf;

endmodule

// File: tb/tb_vchanel_demux.sv
// Scoreboard bench for vchanel_demux: a credit/queue reference model predicts
// each push, and a negedge monitor compares every cycle.
module tb_vchanel_demux;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enb = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        in_dest = 2'd0;
  logic [DATA_W-1:0] in_data = '0;
  logic [3:0]        pop_vchanel = 4'd0;
  logic              in_ready;
  logic              push_vchanel0, push_vchanel1, push_vchanel2, push_vchanel3;
  logic [DATA_W-1:0] data_demux;
  logic [3:0]        full_vchanel;
  logic              overflow_err;

  vchanel_demux #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .in_valid      (in_valid),
    .in_dest       (in_dest),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .pop_vchanel   (pop_vchanel),
    .push_vchanel0 (push_vchanel0),
    .push_vchanel1 (push_vchanel1),
    .push_vchanel2 (push_vchanel2),
    .push_vchanel3 (push_vchanel3),
    .data_demux    (data_demux),
    .full_vchanel  (full_vchanel),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dest;
    int data;
    int due;
  } beat_t;

  beat_t expq[$];
  int    mcredit[4];
  bit    movf;
  int    mlast;
  int    cyc;
  int    checks;
  int    errors;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) mcredit[i] = DEPTH;
    movf  = 1'b0;
    mlast = 0;
    expq.delete();
  endfunction

  // Monitor: the queue front due this cycle defines the only allowed strobe.
  always @(negedge clk) begin
    logic [3:0]  push_v;
    logic [3:0]  exp_push;
    logic [3:0]  exp_full;
    logic [31:0] exp_data;
    beat_t       b;
    push_v   = {push_vchanel3, push_vchanel2, push_vchanel1, push_vchanel0};
    exp_push = 4'd0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      b        = expq.pop_front();
      exp_push = 4'(1 << b.dest);
      mlast    = b.data;
    end
    exp_data = 32'(mlast);
    for (int i = 0; i < 4; i++) exp_full[i] = (mcredit[i] == 0);
    checkOutput("push_vec", 32'(push_v), 32'(exp_push));
    checkOutput("data_demux", 32'(data_demux), exp_data);
    checkOutput("full_vchanel", 32'(full_vchanel), 32'(exp_full));
    checkOutput("overflow_err", 32'(overflow_err), 32'(movf));
    checkOutput("in_ready", 32'(in_ready), 32'(enb && rst && mcredit[in_dest] > 0));
  end

  // Drives one cycle of inputs and advances the reference model at the edge.
  task automatic applyStimulus(input bit v, input logic [1:0] d, input logic [3:0] dat,
                               input logic [3:0] p, input bit e, output bit accepted);
    in_valid    = v;
    in_dest     = d;
    in_data     = dat;
    pop_vchanel = p;
    enb         = e;
    @(posedge clk);
    cyc++;
    accepted = rst && e && v && (mcredit[d] > 0);
    if (rst) begin
      if (accepted) begin
        mcredit[d]--;
        expq.push_back('{int'(d), int'(dat), cyc});
      end
      for (int i = 0; i < 4; i++) begin
        if (p[i]) begin
          if (mcredit[i] == DEPTH) movf = 1'b1;
          else mcredit[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 4'd0, 4'd0, 1'b1, a);
  endtask

  task automatic drainAll();
    bit a;
    logic [3:0] p;
    for (int k = 0; k < DEPTH + 1; k++) begin
      for (int i = 0; i < 4; i++) p[i] = (mcredit[i] < DEPTH);
      applyStimulus(1'b0, 2'd0, 4'd0, p, 1'b1, a);
    end
  endtask

  initial begin
    bit         a;
    bit         holding;
    logic [1:0] rd;
    logic [3:0] rdat;
    checks = 0;
    errors = 0;
    cyc    = 0;
    modelReset();
    idle(2);
    rst = 1'b1;
    idle(1);

    // Single beat to channel 2
    applyStimulus(1'b1, 2'd2, 4'hC, 4'd0, 1'b1, a);
    idle(2);

    // Fill channel 0, fifth beat stalls until a pop frees a credit
    for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 2'd0, 4'(k), 4'd0, 1'b1, a);
    applyStimulus(1'b1, 2'd0, 4'h5, 4'd0, 1'b1, a);
    applyStimulus(1'b1, 2'd0, 4'h5, 4'd0, 1'b1, a);
    applyStimulus(1'b1, 2'd0, 4'h5, 4'b0001, 1'b1, a);
    applyStimulus(1'b1, 2'd0, 4'h5, 4'd0, 1'b1, a);
    checkOutput("stalled_beat_accepted", 32'(a), 32'd1);
    idle(2);
    drainAll();

    // Channel 3 at credit 1: simultaneous accept and pop
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 2'd3, 4'(k + 6), 4'd0, 1'b1, a);
    applyStimulus(1'b1, 2'd3, 4'hE, 4'b1000, 1'b1, a);
    applyStimulus(1'b0, 2'd3, 4'h0, 4'd0, 1'b1, a);
    idle(1);
    drainAll();

    // Back-to-back beats across channels
    applyStimulus(1'b1, 2'd1, 4'hB, 4'd0, 1'b1, a);
    applyStimulus(1'b1, 2'd3, 4'hD, 4'd0, 1'b1, a);
    applyStimulus(1'b1, 2'd0, 4'hA, 4'd0, 1'b1, a);
    applyStimulus(1'b1, 2'd2, 4'h9, 4'd0, 1'b1, a);
    idle(2);
    drainAll();

    // Pop on channel 1 at full credit
    applyStimulus(1'b0, 2'd1, 4'h0, 4'b0010, 1'b1, a);
    idle(2);

    // Enable drops right after an accept, then asynchronous reset mid-stream
    applyStimulus(1'b1, 2'd1, 4'h6, 4'd0, 1'b1, a);
    applyStimulus(1'b1, 2'd1, 4'h7, 4'd0, 1'b0, a);
    applyStimulus(1'b1, 2'd2, 4'h8, 4'd0, 1'b1, a);
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_push", 32'({push_vchanel3, push_vchanel2, push_vchanel1, push_vchanel0}), 32'd0);
    checkOutput("async_reset_full", 32'(full_vchanel), 32'd0);
    checkOutput("async_reset_ovf", 32'(overflow_err), 32'd0);
    applyStimulus(1'b1, 2'd2, 4'h8, 4'd0, 1'b1, a);
    applyStimulus(1'b0, 2'd0, 4'h0, 4'd0, 1'b1, a);
    rst = 1'b1;
    idle(1);

    // Randomised traffic; the source holds a stalled beat until accepted
    holding = 1'b0;
    rd      = 2'd0;
    rdat    = 4'd0;
    for (int n = 0; n < 400; n++) begin
      if (!holding) begin
        rd   = 2'($urandom_range(0, 3));
        rdat = 4'($urandom);
      end
      holding = holding || ($urandom_range(0, 9) < 7);
      applyStimulus(holding, rd, rdat, 4'($urandom & $urandom & $urandom),
                    ($urandom_range(0, 9) != 0), a);
      if (a) holding = 1'b0;
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
